// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request and holds the
// IF/ID register, buffering one returned word while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_buf, hold_nxt;
  logic [31:0] instr_nxt, pp4_nxt;
  logic        vld_nxt;

  assign imem_req  = (state == S_REQ) && !reset;
  assign imem_addr = word_align(pc);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold_buf;
    instr_nxt = instruction;
    pp4_nxt   = pc_plus4;
    vld_nxt   = instr_valid;
    if (redirect) begin
      // Flush: anything buffered or arriving this cycle is on the wrong path.
      state_nxt = S_REQ;
      pc_nxt    = word_align(redirect_pc);
      hold_nxt  = 32'h0000_0000;
      instr_nxt = 32'h0000_0000;
      pp4_nxt   = 32'h0000_0000;
      vld_nxt   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (imem_ready && !stall) begin
            instr_nxt = imem_rdata;
            pp4_nxt   = pc_inc(pc);
            vld_nxt   = 1'b1;
            pc_nxt    = pc_inc(pc);
          end else if (imem_ready && stall) begin
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end else if (!stall) begin
            instr_nxt = 32'h0000_0000;
            vld_nxt   = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_nxt = hold_buf;
            pp4_nxt   = pc_inc(pc);
            vld_nxt   = 1'b1;
            pc_nxt    = pc_inc(pc);
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC_ALIGNED;
      hold_buf    <= 32'h0000_0000;
      instruction <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      hold_buf    <= hold_nxt;
      instruction <= instr_nxt;
      pc_plus4    <= pp4_nxt;
      instr_valid <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, wrap-around sequence on a second
// instance, and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc_plus4;

  logic        reset_b;
  logic [31:0] imem_rdata_b;
  logic        imem_req_b, instr_valid_b;
  logic [31:0] imem_addr_b, instruction_b, pc_plus4_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset_b), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0000_0000), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ready(1'b1), .imem_rdata(imem_rdata_b),
    .instruction(instruction_b), .pc_plus4(pc_plus4_b), .instr_valid(instr_valid_b)
  );

  assign imem_rdata_b = imem_addr_b ^ 32'hA5A5_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        ereq;      // before the edge
    logic [31:0] eaddr;     // before the edge
    logic [31:0] einstr, epp4;
    logic        evld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, stl, rdr, input logic [31:0] rpc, input logic rdy,
                     input logic [31:0] rdata, input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] einstr, epp4, input logic evld);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.epp4 = epp4; v.evld = evld;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, stl, rdr, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rdata);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rdata;
  endtask

  // Reference model: a fetch is either waiting to start, requesting, or parked
  // with one buffered word in a queue until decode accepts it.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_vld, m_idle;
  logic [31:0] m_buf[$];

  task automatic model_step(input logic rst, stl, rdr, input logic [31:0] rpc,
                            input logic rdy, input logic [31:0] rdata);
    if (rst) begin
      m_pc = 32'h0; m_instr = 0; m_pp4 = 0; m_vld = 0; m_idle = 1; m_buf.delete();
    end else if (rdr) begin
      m_pc = {rpc[31:2], 2'b00}; m_instr = 0; m_pp4 = 0; m_vld = 0; m_idle = 0;
      m_buf.delete();
    end else if (m_idle) begin
      m_idle = 0;
    end else if (m_buf.size() > 0) begin
      if (!stl) begin
        m_instr = m_buf.pop_front(); m_pc = m_pc + 4; m_pp4 = m_pc; m_vld = 1;
      end
    end else if (rdy && !stl) begin
      m_instr = rdata; m_pc = m_pc + 4; m_pp4 = m_pc; m_vld = 1;
    end else if (rdy) begin
      m_buf.push_back(rdata);
    end else if (!stl) begin
      m_instr = 0; m_vld = 0;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    reset_b = 1'b1;
    @(negedge clk);
    @(negedge clk);

    //   rst stl rdr rpc            rdy rdata          req addr           instr          pp4            vld
    add(1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0000, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0000,  0, 32'h0000_0000, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0000,  1, 32'h0000_0000, 32'hA5A5_0000,  32'h4,         1);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0004,  1, 32'h0000_0004, 32'hA5A5_0004,  32'h8,         1);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0008,  1, 32'h0000_0008, 32'hA5A5_0008,  32'hC,         1);
    add(0, 1, 0, 32'h0,          1, 32'h2002_0005,  1, 32'h0000_000C, 32'hA5A5_0008,  32'hC,         1);
    add(0, 1, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0000_000C, 32'hA5A5_0008,  32'hC,         1);
    add(0, 1, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0000_000C, 32'hA5A5_0008,  32'hC,         1);
    add(0, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 32'h0000_000C, 32'h2002_0005,  32'h10,        1);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0010,  1, 32'h0000_0010, 32'hA5A5_0010,  32'h14,        1);
    add(0, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  1, 32'h0000_0014, 32'h0,          32'h14,        0);
    add(0, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  1, 32'h0000_0014, 32'h0,          32'h14,        0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0014,  1, 32'h0000_0014, 32'hA5A5_0014,  32'h18,        1);
    add(0, 1, 1, 32'h0000_0043, 1, 32'hBAD0_0001,  1, 32'h0000_0018, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0040,  1, 32'h0000_0040, 32'hA5A5_0040,  32'h44,        1);
    add(0, 1, 0, 32'h0,          1, 32'h1111_1111,  1, 32'h0000_0044, 32'hA5A5_0040,  32'h44,        1);
    add(0, 0, 1, 32'h0000_0100, 1, 32'hBAD0_0002,  0, 32'h0000_0044, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0100,  1, 32'h0000_0100, 32'hA5A5_0100,  32'h104,       1);
    add(0, 1, 0, 32'h0,          1, 32'h2222_2222,  1, 32'h0000_0104, 32'hA5A5_0100,  32'h104,       1);
    add(1, 1, 0, 32'h0,          1, 32'h2222_2222,  0, 32'h0000_0104, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'h3333_3333,  0, 32'h0000_0000, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0000,  1, 32'h0000_0000, 32'hA5A5_0000,  32'h4,         1);
    add(0, 1, 0, 32'h0,          0, 32'hBAD0_0003,  1, 32'h0000_0004, 32'hA5A5_0000,  32'h4,         1);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0004,  1, 32'h0000_0004, 32'hA5A5_0004,  32'h8,         1);
    add(1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0000_0008, 32'h0,          32'h0,         0);
    add(0, 0, 1, 32'h0000_0202, 1, 32'h0,          0, 32'h0000_0000, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'hA5A5_0200,  1, 32'h0000_0200, 32'hA5A5_0200,  32'h204,       1);
    add(1, 0, 1, 32'h0000_0500, 1, 32'h0,          0, 32'h0000_0204, 32'h0,          32'h0,         0);
    add(0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0000_0000, 32'h0,          32'h0,         0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy, vecs[i].rdata);
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].ereq});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      @(posedge clk); #1;
      chk($sformatf("vec%0d instruction", i), instruction, vecs[i].einstr);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].epp4);
      chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].evld});
      @(negedge clk);
    end

    // Wrap-around from RESET_PC = FFFF_FFF8 with continuous ready.
    reset_b = 1'b0;
    #1;
    chk("wrap req idle", {31'b0, imem_req_b}, 32'h0);
    chk("wrap addr0", imem_addr_b, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap bubble", {31'b0, instr_valid_b}, 32'h0);
    @(negedge clk);
    chk("wrap addr1", imem_addr_b, 32'hFFFF_FFF8);
    chk("wrap req1", {31'b0, imem_req_b}, 32'h1);
    @(posedge clk); #1;
    chk("wrap instr1", instruction_b, 32'h5A5A_FFF8);
    chk("wrap pp4_1", pc_plus4_b, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap addr2", imem_addr_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap instr2", instruction_b, 32'h5A5A_FFFC);
    chk("wrap pp4_2", pc_plus4_b, 32'h0000_0000);
    @(negedge clk);
    chk("wrap addr3", imem_addr_b, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap instr3", instruction_b, 32'hA5A5_0000);
    chk("wrap pp4_3", pc_plus4_b, 32'h0000_0004);
    chk("wrap vld3", {31'b0, instr_valid_b}, 32'h1);
    @(negedge clk);
    reset_b = 1'b1;

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_stl, r_rdr, r_rdy;
      logic [31:0] r_rpc, r_rdata;
      r_rst   = ($urandom_range(0, 59) == 0);
      r_rdr   = ($urandom_range(0, 11) == 0);
      r_stl   = ($urandom_range(0, 2) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_rpc   = $urandom;
      r_rdata = $urandom;
      drive(r_rst, r_stl, r_rdr, r_rpc, r_rdy, r_rdata);
      #1;
      chk("rnd imem_req", {31'b0, imem_req},
          {31'b0, (!r_rst && !m_idle && m_buf.size() == 0)});
      chk("rnd imem_addr", imem_addr, m_pc);
      model_step(r_rst, r_stl, r_rdr, r_rpc, r_rdy, r_rdata);
      @(posedge clk); #1;
      chk("rnd instruction", instruction, m_instr);
      chk("rnd pc_plus4", pc_plus4, m_pp4);
      chk("rnd instr_valid", {31'b0, instr_valid}, {31'b0, m_vld});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset; bits [1:0] SHALL be treated as 0.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard hold; 1 = freeze decode-side outputs.
- redirect  input  1  branch/jump taken; flush and reload PC.
- redirect_pc  input  32  new PC on redirect.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  word address being requested (= pc).
- imem_ready  input  1  imem_rdata valid this cycle for the pending request.
- imem_rdata  input  32  fetched instruction word.
- instruction  output  32  IF/ID register, feeding the decode stage.
- pc_plus4  output  32  PC+4 of the held instruction.
- instr_valid  output  1  instruction holds a real fetch; 0 = bubble.

Function
REQ-003 SHALL keep a 3-state FSM: S_IDLE, S_REQ, S_HOLD.
REQ-004 SHALL keep an internal 32-bit pc register and a 32-bit hold buffer.
REQ-005 imem_addr SHALL equal pc combinationally, with bits [1:0] always 0.
REQ-006 imem_req SHALL be 1 only in S_REQ.
REQ-007 From S_IDLE, with no redirect, the FSM SHALL go to S_REQ next cycle, giving one bubble after reset.
REQ-008 In S_REQ with imem_ready=1, stall=0 and redirect=0, the block SHALL, on the same edge:
- load instruction<=imem_rdata, pc_plus4<=pc+4 and instr_valid<=1;
- advance pc<=pc+4;
- stay in S_REQ.
REQ-009 In S_REQ with imem_ready=1, stall=1 and redirect=0, the block SHALL:
- capture imem_rdata into the hold buffer;
- keep pc, instruction, pc_plus4 and instr_valid unchanged;
- go to S_HOLD.
REQ-010 In S_REQ with imem_ready=0 and redirect=0:
- with stall=0, the block SHALL load instruction<=32'h0000_0000 and instr_valid<=0, keeping pc;
- with stall=1, all outputs SHALL hold.
REQ-011 In S_HOLD with stall=1 and redirect=0, all state SHALL hold and imem_req SHALL be 0.
REQ-012 In S_HOLD with stall=0 and redirect=0, the block SHALL:
- load instruction<=hold buffer, pc_plus4<=pc+4 and instr_valid<=1;
- advance pc<=pc+4;
- go to S_REQ.
REQ-013 redirect=1 SHALL take priority over stall and imem_ready in every state. On that edge the block SHALL:
- set pc<={redirect_pc[31:2],2'b00};
- set instruction<=0, instr_valid<=0 and pc_plus4<=0;
- discard the hold buffer and any imem_rdata arriving that cycle;
- go to S_REQ.
REQ-014 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-015 The block SHALL fetch at most one instruction per cycle, so steady-state throughput is 1 instruction per cycle while imem_ready=1 and stall=0.
REQ-016 instruction SHALL change only per REQ-008, REQ-010, REQ-012 and REQ-013; a stall SHALL never drop or duplicate an instruction.

Reset
REQ-017 With reset=1 at a clock edge, the block SHALL set:
- state=S_IDLE and pc=RESET_PC;
- instruction=0, pc_plus4=0 and instr_valid=0;
- hold buffer=0.
REQ-018 reset SHALL override redirect and stall.
REQ-019 Reset asserted mid-S_HOLD or mid-S_REQ SHALL abandon the pending fetch; no buffered word SHALL appear afterwards.
REQ-020 While reset=1, imem_req SHALL be 0.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset then imem_ready=1 constantly, with rdata=addr^32'hA5A5_0000. Expected: cycle 1 after reset imem_req=0; then instr_valid=1 with instruction=32'hA5A5_0000 and pc_plus4=4, then 0xA5A5_0004 and pc_plus4=8, and so on.
- Stall asserted for 3 cycles while rdata=32'h2002_0005 arrives. Expected: outputs frozen on the previous instruction, imem_req=0 in S_HOLD; the cycle after stall drops, instruction=32'h2002_0005 and instr_valid=1; no instruction is skipped or repeated.
- redirect=1 with redirect_pc=32'h0000_0043 while stall=1 and imem_ready=1. Expected next cycle: imem_addr=32'h0000_0040, instr_valid=0, instruction=0, and the stale rdata is never presented.
- imem_ready=0 for 2 cycles with stall=0. Expected: two bubbles (instr_valid=0, instruction=0) and imem_addr unchanged.
- RESET_PC=32'hFFFF_FFF8 with continuous ready. Expected: imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, and pc_plus4 for the second fetch = 32'h0000_0000.
- reset=1 during S_HOLD. Expected next cycle: instr_valid=0 and imem_addr=RESET_PC, and the held word is never output.
